cam_frame_grabber: RTL and testbench

CAM_FRAME_GRABBER -- requirements
Module: cam_frame_grabber

---
 rtl/cam_frame_grabber_pkg.sv | 36 +++
 rtl/cam_frame_grabber_byte_pair.sv | 34 +++
 rtl/cam_frame_grabber.sv | 185 ++++++++++++++++++
 tb/tb_cam_frame_grabber.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cam_frame_grabber_pkg.sv
// Shared types, field positions and helpers for the camera frame grabber.
// Pixel conversion packs the top three bits of each colour (or of luma) into 9 bits.
package cam_frame_grabber_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Top bit positions of the 3-bit fields taken from the 16-bit camera word
  localparam int RGB_R_TOP = 15;
  localparam int RGB_G_TOP = 10;
  localparam int RGB_B_TOP = 4;
  localparam int YUV_Y_TOP = 15;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [8:0] to_pixel(input logic [15:0] word, input logic yuv);
    logic [2:0] y3;
    y3 = word[YUV_Y_TOP -: 3];
    if (yuv) begin
      to_pixel = {y3, y3, y3};
    end else begin
      to_pixel = {word[RGB_R_TOP -: 3], word[RGB_G_TOP -: 3], word[RGB_B_TOP -: 3]};
    end
  endfunction

endpackage

// File: rtl/cam_frame_grabber_byte_pair.sv
// Pairs camera bytes into 16-bit words while HREF is high; high byte first.
// Any HREF gap (or an explicit clear) restarts pairing, so a trailing odd byte is dropped.
module cam_byte_pair
  import cam_frame_grabber_pkg::*;
(
  input  logic        ov_pclk,
  input  logic        rst,
  input  logic        clr,
  input  logic        ov_hs,
  input  logic [7:0]  cam_data,
  output logic [15:0] word,
  output logic        word_valid
);

  logic       r_phase;
  logic [7:0] r_hi;

  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      r_phase <= 1'b0;
      r_hi    <= 8'h00;
    end else if (clr || !ov_hs) begin
      r_phase <= 1'b0;
      r_hi    <= r_hi;
    end else begin
      r_phase <= ~r_phase;
      r_hi    <= r_phase ? r_hi : cam_data;
    end
  end

  assign word       = {r_hi, cam_data};
  assign word_valid = ov_hs & r_phase;

endmodule

// File: rtl/cam_frame_grabber.sv
// Camera capture into a decimated double-buffered frame store, read from a second clock.
// A frame is committed (bank swap) only if exactly CAM_H lines arrived before the next VSYNC.
module cam_frame_grabber
  import cam_frame_grabber_pkg::*;
#(
  parameter int CAM_W = 640,
  parameter int CAM_H = 480,
  parameter int DEC   = 4,
  parameter int PIX_W = 9,
  localparam int XB   = clog2(CAM_W / DEC),
  localparam int YB   = clog2(CAM_H / DEC)
) (
  input  logic             ov_pclk,
  input  logic             rst,
  input  logic             mem_clk,
  input  logic             ov_vs,
  input  logic             ov_hs,
  input  logic [7:0]       cam_data,
  input  logic             work_en,
  input  logic             mode,
  input  logic [XB-1:0]    rd_x,
  input  logic [YB-1:0]    rd_y,
  output logic [PIX_W-1:0] rd_data,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      drop_cnt,
  output logic             ov_rst,
  output logic             ov_pwdn
);

  localparam int XW      = clog2(CAM_W + 1);
  localparam int YW      = clog2(CAM_H + 2);
  localparam int LOG_DEC = clog2(DEC);
  localparam int AW      = 1 + YB + XB;
  localparam logic [XW-1:0] X_END    = XW'(CAM_W);
  localparam logic [YW-1:0] Y_END    = YW'(CAM_H);
  localparam logic [XW-1:0] X_MASK   = XW'(DEC - 1);
  localparam logic [YW-1:0] Y_MASK   = YW'(DEC - 1);
  localparam logic [XB:0]   RD_X_END = (XB + 1)'(CAM_W / DEC);
  localparam logic [YB:0]   RD_Y_END = (YB + 1)'(CAM_H / DEC);

  state_t           r_state, w_next;
  logic             r_vs_d, r_hs_d, r_wb, r_mode, r_frame_done;
  logic [15:0]      r_frame_cnt, r_drop_cnt;
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic             w_vs_rise, w_vs_fall, w_hs_fall;
  logic             w_start, w_commit, w_drop, w_wr_en;
  logic [15:0]      w_word;
  logic             w_word_valid;
  logic [AW-1:0]    w_wr_addr;
  logic [PIX_W-1:0] r_mem [0:(1 << AW) - 1];
  logic [1:0]       r_mrst, r_db_sync;
  logic             w_mrst_n, w_db;
  logic [PIX_W-1:0] r_rd_data;

  assign w_vs_rise = ov_vs & ~r_vs_d;
  assign w_vs_fall = ~ov_vs & r_vs_d;
  assign w_hs_fall = ~ov_hs & r_hs_d;

  cam_byte_pair u_pair (
    .ov_pclk    (ov_pclk),
    .rst        (rst),
    .clr        (w_start),
    .ov_hs      (ov_hs),
    .cam_data   (cam_data),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_vs_d  <= 1'b0;
      r_hs_d  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vs_d  <= ov_vs;
      r_hs_d  <= ov_hs;
    end
  end

  // The enable is only looked at on VSYNC rise, so a running frame always completes
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_commit = 1'b0;
    w_drop   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_rise && work_en) w_next = ST_SYNC;
        else                      w_next = ST_IDLE;
      end
      ST_SYNC: begin
        if (w_vs_fall) begin
          w_next  = ST_ACTIVE;
          w_start = 1'b1;
        end else begin
          w_next = ST_SYNC;
        end
      end
      ST_ACTIVE: begin
        if (w_vs_rise) begin
          w_next   = work_en ? ST_SYNC : ST_IDLE;
          w_commit = (r_y == Y_END);
          w_drop   = (r_y != Y_END);
        end else begin
          w_next = ST_ACTIVE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // x and y saturate one past the active area so long frames and lines stay detectable
  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      r_x    <= {XW{1'b0}};
      r_y    <= {YW{1'b0}};
      r_mode <= 1'b0;
    end else if (w_start) begin
      r_x    <= {XW{1'b0}};
      r_y    <= {YW{1'b0}};
      r_mode <= mode;
    end else if (r_state == ST_ACTIVE && w_hs_fall) begin
      r_x <= {XW{1'b0}};
      r_y <= (r_y <= Y_END) ? r_y + YW'(1) : r_y;
    end else if (r_state == ST_ACTIVE && w_word_valid && r_x < X_END) begin
      r_x <= r_x + XW'(1);
    end
  end

  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      r_wb         <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 16'd0;
      r_drop_cnt   <= 16'd0;
    end else begin
      r_wb         <= r_wb ^ w_commit;
      r_frame_done <= w_commit;
      r_frame_cnt  <= r_frame_cnt + {15'd0, w_commit};
      r_drop_cnt   <= r_drop_cnt + {15'd0, w_drop};
    end
  end

  assign w_wr_en = (r_state == ST_ACTIVE) && w_word_valid && (r_x < X_END) && (r_y < Y_END) &&
                   ((r_x & X_MASK) == {XW{1'b0}}) && ((r_y & Y_MASK) == {YW{1'b0}});
  assign w_wr_addr = {r_wb, YB'(r_y >> LOG_DEC), XB'(r_x >> LOG_DEC)};

  always_ff @(posedge ov_pclk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= PIX_W'(to_pixel(w_word, r_mode));
  end

  // Read-domain reset: asserted with rst, released on mem_clk
  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst) r_mrst <= 2'b00;
    else      r_mrst <= {r_mrst[0], 1'b1};
  end
  assign w_mrst_n = r_mrst[1];

  always_ff @(posedge mem_clk or negedge w_mrst_n) begin
    if (!w_mrst_n) r_db_sync <= 2'b11;
    else           r_db_sync <= {r_db_sync[0], ~r_wb};
  end
  assign w_db = r_db_sync[1];

  always_ff @(posedge mem_clk or negedge w_mrst_n) begin
    if (!w_mrst_n) begin
      r_rd_data <= {PIX_W{1'b0}};
    end else if (({1'b0, rd_x} < RD_X_END) && ({1'b0, rd_y} < RD_Y_END)) begin
      r_rd_data <= r_mem[{w_db, rd_y, rd_x}];
    end else begin
      r_rd_data <= {PIX_W{1'b0}};
    end
  end

  assign rd_data    = r_rd_data;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign drop_cnt   = r_drop_cnt;
  assign ov_rst     = 1'b1;
  assign ov_pwdn    = 1'b0;

endmodule

// File: tb/tb_cam_frame_grabber.sv
// Directed bench for cam_frame_grabber on a scaled 20x12 sensor (DEC=4 gives a 5x3 store).
// Readback expectations are a table keyed by scenario; counters and pulses are checked inline.
module tb_cam_frame_grabber;

  logic       ov_pclk = 1'b0;
  logic       mem_clk = 1'b0;
  logic       rst = 1'b0;
  logic       ov_vs = 1'b0;
  logic       ov_hs = 1'b0;
  logic       work_en = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic [2:0] rd_x = 3'd0;
  logic [1:0] rd_y = 2'd0;
  logic [8:0] rd_data;
  logic       frame_done;
  logic [15:0] frame_cnt, drop_cnt;
  logic       ov_rst, ov_pwdn;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         phase;
    logic [2:0] x;
    logic [1:0] y;
    logic [8:0] exp;
  } rd_vec_t;
  rd_vec_t vecs[$];

  always #5 ov_pclk = ~ov_pclk;
  always #7 mem_clk = ~mem_clk;

  cam_frame_grabber #(.CAM_W(20), .CAM_H(12), .DEC(4), .PIX_W(9)) dut (
    .ov_pclk    (ov_pclk),
    .rst        (rst),
    .mem_clk    (mem_clk),
    .ov_vs      (ov_vs),
    .ov_hs      (ov_hs),
    .cam_data   (cam_data),
    .work_en    (work_en),
    .mode       (mode),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .ov_rst     (ov_rst),
    .ov_pwdn    (ov_pwdn)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int ph, input int x, input int y, input logic [8:0] e);
    rd_vec_t v;
    v.phase = ph;
    v.x = 3'(x);
    v.y = 2'(y);
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic run_reads(input int ph);
    repeat (6) @(posedge mem_clk);
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph) begin
        @(negedge mem_clk);
        rd_x = vecs[i].x;
        rd_y = vecs[i].y;
        @(posedge mem_clk);
        #1;
        check($sformatf("rd%0d(%0d,%0d)", ph, vecs[i].x, vecs[i].y), 16'(rd_data), 16'(vecs[i].exp));
      end
    end
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] hi, input logic [7:0] lo,
                           input logic [7:0] odd);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge ov_pclk);
      ov_hs = 1'b1;
      if (i % 2 == 1)          cam_data = lo;
      else if (i == nbytes - 1) cam_data = odd;
      else                     cam_data = hi;
    end
    @(negedge ov_pclk);
    ov_hs = 1'b0;
    cam_data = 8'h00;
    repeat (3) @(negedge ov_pclk);
  endtask

  task automatic send_lines(input int n, input logic [7:0] hi, input logic [7:0] lo);
    for (int l = 0; l < n; l++) send_line(40, hi, lo, hi);
  endtask

  task automatic vs_edge(input logic exp_done);
    @(negedge ov_pclk);
    ov_vs = 1'b1;
    @(posedge ov_pclk);
    #1;
    check("frame_done_pulse", 16'(frame_done), 16'(exp_done));
    @(posedge ov_pclk);
    #1;
    check("frame_done_clear", 16'(frame_done), 16'd0);
    @(negedge ov_pclk);
    ov_vs = 1'b0;
    repeat (3) @(negedge ov_pclk);
  endtask

  task automatic check_cnt(input logic [15:0] fc, input logic [15:0] dc);
    check("frame_cnt", frame_cnt, fc);
    check("drop_cnt", drop_cnt, dc);
  endtask

  initial begin
    // Phase 1: F800 RGB frame; mode flips mid-frame and must not take effect
    add(1, 0, 0, 9'h1C0); add(1, 4, 2, 9'h1C0); add(1, 2, 1, 9'h1C0);
    add(1, 5, 0, 9'h000); add(1, 0, 3, 9'h000); add(1, 7, 3, 9'h000);
    // Phase 2: YUV frame, Y=A0
    add(2, 0, 0, 9'h16D); add(2, 3, 2, 9'h16D); add(2, 1, 1, 9'h16D);
    // Phase 3: truncated frame leaves the displayed bank alone
    add(3, 0, 0, 9'h16D); add(3, 0, 1, 9'h16D); add(3, 4, 2, 9'h16D);
    // Phase 4: 001F frame with an odd-byte line just before row 1
    add(4, 0, 0, 9'h007); add(4, 0, 1, 9'h007); add(4, 4, 1, 9'h007); add(4, 4, 2, 9'h007);
    // Phase 5: first frame after a mid-frame reset (07E0 = green)
    add(5, 0, 0, 9'h038); add(5, 4, 2, 9'h038);
    // Phase 6: frame completed after work_en dropped mid-frame
    add(6, 0, 0, 9'h1C0); add(6, 4, 2, 9'h1C0); add(6, 6, 1, 9'h000);

    repeat (3) @(negedge ov_pclk);
    check("rst_frame_done", 16'(frame_done), 16'd0);
    check_cnt(16'd0, 16'd0);
    check("ov_rst", 16'(ov_rst), 16'd1);
    check("ov_pwdn", 16'(ov_pwdn), 16'd0);
    check("rst_rd_data", 16'(rd_data), 16'd0);
    rst = 1'b1;
    work_en = 1'b1;
    mode = 1'b0;
    repeat (4) @(negedge ov_pclk);

    vs_edge(1'b0);
    send_lines(2, 8'hF8, 8'h00);
    mode = 1'b1;
    send_lines(10, 8'hF8, 8'h00);
    vs_edge(1'b1);
    check_cnt(16'd1, 16'd0);
    run_reads(1);

    send_lines(3, 8'hA0, 8'h80);
    mode = 1'b0;
    send_lines(9, 8'hA0, 8'h80);
    vs_edge(1'b1);
    check_cnt(16'd2, 16'd0);
    run_reads(2);

    send_lines(7, 8'h00, 8'h1F);
    vs_edge(1'b0);
    check_cnt(16'd2, 16'd1);
    run_reads(3);

    send_lines(3, 8'h00, 8'h1F);
    send_line(41, 8'h00, 8'h1F, 8'hFF);
    send_lines(8, 8'h00, 8'h1F);
    vs_edge(1'b1);
    check_cnt(16'd3, 16'd1);
    run_reads(4);

    send_lines(5, 8'hF8, 8'h00);
    @(negedge ov_pclk);
    rst = 1'b0;
    #1;
    check_cnt(16'd0, 16'd0);
    check("mid_rst_rd_data", 16'(rd_data), 16'd0);
    repeat (2) @(negedge ov_pclk);
    rst = 1'b1;
    repeat (2) @(negedge ov_pclk);
    send_lines(7, 8'hF8, 8'h00);
    vs_edge(1'b0);
    check_cnt(16'd0, 16'd0);
    send_lines(12, 8'h07, 8'hE0);
    vs_edge(1'b1);
    check_cnt(16'd1, 16'd0);
    run_reads(5);

    send_lines(4, 8'hF8, 8'h00);
    work_en = 1'b0;
    send_lines(8, 8'hF8, 8'h00);
    vs_edge(1'b1);
    check_cnt(16'd2, 16'd0);
    vs_edge(1'b0);
    send_lines(12, 8'h07, 8'hE0);
    vs_edge(1'b0);
    check_cnt(16'd2, 16'd0);
    run_reads(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
